// File: rtl/iic_slave_rx.sv
// iic_slave_rx: receive-only I2C slave.
// Oversamples SCL/SDA on clk, detects START/STOP, matches a 7-bit write
// address, shifts in data bytes MSB-first, ACKs/NACKs on SDA and hands each
// received byte to local logic as a one-cycle strobe.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   scl_i      SCL bus level (asynchronous)
//   sda_i      SDA bus level (asynchronous)
//   rx_en      1 = ACK data bytes, 0 = NACK data bytes
//   sda_oen_n  0 = pull SDA low, 1 = release
//   rx_data    last accepted data byte
//   rx_valid   one-cycle strobe, rx_data new this cycle
//   rx_first   qualifies rx_valid: first data byte after the address
//   addr_match high from address ACK until STOP or repeated START
//   busy       high between START and STOP
//   stop_det   one-cycle strobe on STOP
module iic_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic       rx_en,
  output logic       sda_oen_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       addr_match,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;

  logic scl_s;
  logic sda_s;
  logic start_s;
  logic stop_s;
  logic scl_rise_s;
  logic scl_fall_s;
  logic last_bit_s;
  logic [7:0] byte_s;

  state_e     state_q,      state_d;
  logic [2:0] bitcnt_q,     bitcnt_d;
  logic [7:0] shift_q,      shift_d;
  logic       first_q,      first_d;
  logic       ack_phase_q,  ack_phase_d;
  logic       rx_en_q,      rx_en_d;
  logic       sda_oen_n_q,  sda_oen_n_d;
  logic [7:0] rx_data_q,    rx_data_d;
  logic       rx_valid_q,   rx_valid_d;
  logic       rx_first_q,   rx_first_d;
  logic       addr_match_q, addr_match_d;
  logic       busy_q,       busy_d;
  logic       stop_det_q,   stop_det_d;

  // Synchroniser chains plus one history flop per line; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign start_s    = scl_s &  sda_hist_q & ~sda_s;
  assign stop_s     = scl_s & ~sda_hist_q &  sda_s;
  assign scl_rise_s =  scl_s & ~scl_hist_q;
  assign scl_fall_s = ~scl_s &  scl_hist_q;
  // Explicit 8th-bit flag: the counter never has to wrap to mean "byte done".
  assign last_bit_s = (bitcnt_q == 3'd7);
  assign byte_s     = {shift_q[6:0], sda_s};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      first_q      <= 1'b0;
      ack_phase_q  <= 1'b0;
      rx_en_q      <= 1'b0;
      sda_oen_n_q  <= 1'b1;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      stop_det_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      first_q      <= first_d;
      ack_phase_q  <= ack_phase_d;
      rx_en_q      <= rx_en_d;
      sda_oen_n_q  <= sda_oen_n_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
      stop_det_q   <= stop_det_d;
    end
  end

  // Next-state and output logic; STOP outranks START, START outranks bit sampling.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    first_d      = first_q;
    ack_phase_d  = ack_phase_q;
    rx_en_d      = rx_en_q;
    sda_oen_n_d  = sda_oen_n_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = 1'b0;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;
    stop_det_d   = 1'b0;

    if (stop_s) begin
      state_d      = ST_IDLE;
      bitcnt_d     = 3'd0;
      ack_phase_d  = 1'b0;
      sda_oen_n_d  = 1'b1;
      addr_match_d = 1'b0;
      busy_d       = 1'b0;
      stop_det_d   = 1'b1;
    end else if (start_s) begin
      state_d      = ST_ADDR;
      bitcnt_d     = 3'd0;
      ack_phase_d  = 1'b0;
      first_d      = 1'b0;
      sda_oen_n_d  = 1'b1;
      addr_match_d = 1'b0;
      busy_d       = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oen_n_d = 1'b1;
        end

        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d  = byte_s;
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit_s) begin
              bitcnt_d    = 3'd0;
              ack_phase_d = 1'b0;
              // Receive-only: a read request is left unacknowledged.
              if ((byte_s[7:1] == SLAVE_ADDR) && (byte_s[0] == 1'b0)) begin
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!ack_phase_q) begin
              ack_phase_d  = 1'b1;
              sda_oen_n_d  = 1'b0;
              addr_match_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              sda_oen_n_d = 1'b1;
              bitcnt_d    = 3'd0;
              first_d     = 1'b1;
              state_d     = ST_DATA;
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end

        ST_DATA: begin
          if (scl_rise_s) begin
            shift_d  = byte_s;
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit_s) begin
              bitcnt_d    = 3'd0;
              rx_en_d     = rx_en;
              ack_phase_d = 1'b0;
              first_d     = 1'b0;
              state_d     = ST_DATA_ACK;
              // rx_data only moves for bytes that are actually accepted.
              if (rx_en) begin
                rx_data_d  = byte_s;
                rx_valid_d = 1'b1;
                rx_first_d = first_q;
              end else begin
                rx_valid_d = 1'b0;
              end
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end

        ST_DATA_ACK: begin
          if (scl_fall_s) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              sda_oen_n_d = ~rx_en_q;
            end else begin
              ack_phase_d = 1'b0;
              sda_oen_n_d = 1'b1;
              bitcnt_d    = 3'd0;
              if (rx_en_q) begin
                state_d = ST_DATA;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end else begin
            state_d = ST_DATA_ACK;
          end
        end

        ST_IGNORE: begin
          sda_oen_n_d = 1'b1;
        end

        default: begin
          state_d     = ST_IDLE;
          sda_oen_n_d = 1'b1;
        end
      endcase
    end
  end

  assign sda_oen_n  = sda_oen_n_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_first   = rx_first_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;
  assign stop_det   = stop_det_q;

endmodule

// File: tb/tb_iic_slave_rx.sv
// tb_iic_slave_rx: directed bench for iic_slave_rx with an open-drain SDA
// model, a bit-banged bus master and a scoreboard of expected received bytes.
module tb_iic_slave_rx;

  localparam int HALF = 8;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       rx_en;
  logic       sda_oen_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       addr_match;
  logic       busy;
  logic       stop_det;
  logic       sda_bus;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int stop_cnt = 0;
  int exp_rx = 0;
  int exp_stop = 0;
  logic [8:0] sb_q[$];
  logic       ack;

  assign sda_bus = sda_m & sda_oen_n;

  iic_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .rx_en      (rx_en),
    .sda_oen_n  (sda_oen_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_first   (rx_first),
    .addr_match (addr_match),
    .busy       (busy),
    .stop_det   (stop_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(HALF);
    scl_m = 1'b1; wait_clk(HALF);
    sda_m = 1'b0; wait_clk(HALF);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(2);
    sda_m = 1'b0; wait_clk(HALF);
    scl_m = 1'b1; wait_clk(HALF);
    sda_m = 1'b1; wait_clk(HALF);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2);
    sda_m = b;    wait_clk(HALF);
    scl_m = 1'b1; wait_clk(HALF);
    scl_m = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_clock(output logic a);
    wait_clk(2);
    sda_m = 1'b1; wait_clk(HALF);
    scl_m = 1'b1; wait_clk(HALF - 1);
    a = sda_bus;
    wait_clk(1);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    send_bits(b);
    ack_clock(a);
  endtask

  task automatic check_release(input string tag);
    wait_clk(6);
    check(tag, sda_oen_n, 1'b1);
  endtask

  // Scoreboard pop on every rx_valid, plus STOP strobe counting.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rx_cnt++;
      if (sb_q.size() == 0) begin
        check("rx_spurious_depth", sb_q.size(), 1);
      end else begin
        check("rx_byte", {rx_first, rx_data}, sb_q.pop_front());
      end
    end
    if (!rst && stop_det) stop_cnt++;
  end

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_en = 1'b1;
    wait_clk(4);
    check("rst_oen",   sda_oen_n,  1'b1);
    check("rst_data",  rx_data,    8'h00);
    check("rst_valid", rx_valid,   1'b0);
    check("rst_first", rx_first,   1'b0);
    check("rst_match", addr_match, 1'b0);
    check("rst_busy",  busy,       1'b0);
    check("rst_stop",  stop_det,   1'b0);
    rst = 1'b0;
    wait_clk(4);

    // Reset while the address ACK is driven.
    bus_start();
    check("busy_after_start", busy, 1'b1);
    send_bits(8'hA0);
    wait_clk(6);
    check("addr_ack_drive", sda_oen_n, 1'b0);
    check("addr_match_set", addr_match, 1'b1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("midrst_oen",   sda_oen_n,  1'b1);
    check("midrst_busy",  busy,       1'b0);
    check("midrst_match", addr_match, 1'b0);
    bus_start();
    write_byte(8'hA0, ack);
    check("post_rst_addr_ack", ack, 1'b0);
    check_release("post_rst_ack_release");
    bus_stop(); exp_stop++;
    wait_clk(4);
    check("stop_cnt_1", stop_cnt, exp_stop);
    check("busy_after_stop", busy, 1'b0);

    // Write 0x50/W, 0xA5, 0x3C.
    bus_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", ack, 1'b0);
    check_release("wr_addr_release");
    check("wr_match", addr_match, 1'b1);
    sb_q.push_back({1'b1, 8'hA5}); exp_rx++;
    write_byte(8'hA5, ack);
    check("wr_a5_ack", ack, 1'b0);
    check_release("wr_a5_release");
    check("wr_match_mid", addr_match, 1'b1);
    sb_q.push_back({1'b0, 8'h3C}); exp_rx++;
    write_byte(8'h3C, ack);
    check("wr_3c_ack", ack, 1'b0);
    check_release("wr_3c_release");
    check("wr_rx_cnt", rx_cnt, exp_rx);
    bus_stop(); exp_stop++;
    wait_clk(4);
    check("wr_stop_cnt", stop_cnt, exp_stop);
    check("wr_match_after_stop", addr_match, 1'b0);
    check("wr_hold_data", rx_data, 8'h3C);

    // Wrong address 0x51/W.
    bus_start();
    write_byte(8'hA2, ack);
    check("bad_addr_nack", ack, 1'b1);
    check("bad_addr_match", addr_match, 1'b0);
    write_byte(8'h11, ack);
    check("bad_addr_data_nack", ack, 1'b1);
    check("bad_addr_busy", busy, 1'b1);
    bus_stop(); exp_stop++;
    wait_clk(4);
    check("bad_addr_busy_stop", busy, 1'b0);
    check("bad_addr_rx_cnt", rx_cnt, exp_rx);

    // Read request 0x50/R.
    bus_start();
    write_byte(8'hA1, ack);
    check("read_nack", ack, 1'b1);
    write_byte(8'h22, ack);
    check("read_data_nack", ack, 1'b1);
    bus_stop(); exp_stop++;
    wait_clk(4);
    check("read_rx_cnt", rx_cnt, exp_rx);

    // rx_en=0 during 0x77, then ignored until repeated START.
    bus_start();
    write_byte(8'hA0, ack);
    check("dis_addr_ack", ack, 1'b0);
    rx_en = 1'b0;
    write_byte(8'h77, ack);
    check("dis_77_nack", ack, 1'b1);
    rx_en = 1'b1;
    write_byte(8'h66, ack);
    check("dis_66_nack", ack, 1'b1);
    check("dis_rx_cnt", rx_cnt, exp_rx);
    bus_start();
    write_byte(8'hA0, ack);
    check("dis_rs_addr_ack", ack, 1'b0);
    sb_q.push_back({1'b1, 8'h12}); exp_rx++;
    write_byte(8'h12, ack);
    check("dis_rs_12_ack", ack, 1'b0);
    bus_stop(); exp_stop++;
    wait_clk(4);
    check("dis_rx_cnt_2", rx_cnt, exp_rx);

    // Repeated START after 4 data bits.
    bus_start();
    write_byte(8'hA0, ack);
    check("rs_addr_ack", ack, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_start();
    wait_clk(4);
    check("rs_match_clear", addr_match, 1'b0);
    check("rs_busy", busy, 1'b1);
    write_byte(8'hA0, ack);
    check("rs_readdr_ack", ack, 1'b0);
    sb_q.push_back({1'b1, 8'h81}); exp_rx++;
    write_byte(8'h81, ack);
    check("rs_81_ack", ack, 1'b0);
    bus_stop(); exp_stop++;
    wait_clk(4);
    check("final_rx_cnt", rx_cnt, exp_rx);
    check("final_stop_cnt", stop_cnt, exp_stop);
    check("sb_empty", sb_q.size(), 0);
    check("final_data", rx_data, 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iic_slave_rx.md
Name: iic_slave_rx

Overview:
Receive-only I2C slave. It sits directly downstream of the I2C master controller on the same bus and consumes the SCL/SDA traffic that the master produces. It oversamples the bus on the system clock, detects START/STOP, matches a 7-bit address and shifts in write-data bytes MSB-first. It drives ACK/NACK and presents each byte to local logic as a one-cycle strobe.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this slave answers to.
SYNC_STAGES, 2, synchroniser depth on scl_i/sda_i (legal values 2..3).

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
scl_i  input  1  SCL bus level (asynchronous).
sda_i  input  1  SDA bus level (asynchronous).
rx_en  input  1  1 = accept data bytes (ACK); 0 = NACK data bytes.
sda_oen_n  output  1  0 = pull SDA low; 1 = release. The SDA output level is implicitly 0.
rx_data  output  8  last received data byte.
rx_valid  output  1  one-cycle strobe; rx_data is new this cycle.
rx_first  output  1  qualifies rx_valid: first data byte after the address.
addr_match  output  1  high from address ACK until STOP or repeated START.
busy  output  1  high between START and STOP.
stop_det  output  1  one-cycle strobe on STOP.

Behaviour:
- Reset (rst=1 at posedge clk):
  - Outputs: sda_oen_n=1, rx_data=8'h00, rx_valid=0, rx_first=0, addr_match=0, busy=0, stop_det=0.
  - State=IDLE; bit counter=0; synchronisers and history flops loaded with 1.
  - Reset mid-transfer releases SDA on the same edge.
- Sampling:
  - scl_i/sda_i pass through SYNC_STAGES flops, then one history flop.
  - Edge and condition detection uses only the synchronised signals (scl_s, sda_s) and their history copies.
- Bus conditions:
  - START: scl_s=1 and sda_s falls.
  - STOP: scl_s=1 and sda_s rises.
  - Bit sample: scl_s rises.
  - Drive change point: scl_s falls.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- START from any state (including repeated START):
  - Go to ADDR, clear the bit counter, busy=1, addr_match=0, sda_oen_n=1.
  - START has priority over a bit sample in the same cycle.
- STOP from any state:
  - Go to IDLE, busy=0, addr_match=0, sda_oen_n=1, stop_det=1 for one cycle.
  - STOP has priority over everything except rst.
- ADDR:
  - Shift sda_s into the shift register MSB-first on each SCL rise.
  - On the 8th bit, compare shift[7:1] with SLAVE_ADDR and bit0 (R/W).
  - Match and R/W=0: go to ADDR_ACK.
  - Otherwise: go to IGNORE. Read requests are NACKed because the slave is receive-only.
- ADDR_ACK:
  - On the next SCL fall: sda_oen_n=0, addr_match=1.
  - On the following SCL fall: sda_oen_n=1, go to DATA, counter=0, set the first-byte flag.
- DATA:
  - Shift on each SCL rise.
  - On the 8th sample, in the same cycle as the sample: rx_data=byte; rx_valid=1 if rx_en=1; rx_first=first-byte flag.
  - Then clear the first-byte flag and go to DATA_ACK.
- DATA_ACK:
  - rx_en is sampled at the 8th bit.
  - rx_en=1: ACK. Drive sda_oen_n=0 on the next SCL fall, release on the following SCL fall, go to DATA.
  - rx_en=0: do not drive, go to IGNORE on the same fall where an ACK would have ended.
- IGNORE: sda_oen_n held at 1; leave only on START or STOP.
- Latency: rx_valid asserts SYNC_STAGES+1 clk cycles after scl_i rises for bit 0 (LSB) at the pin.
- rx_valid and stop_det are single-cycle. rx_data holds its value until the next accepted byte.
- The bit counter is 3 bits with an explicit 8th-bit flag, so there is no wrap ambiguity.
- Glitches on SDA while scl_s=1 are treated as START/STOP by design.
- The bus master must keep SCL high/low phases at least SYNC_STAGES+2 clk cycles long.

Test Plan:
- Reset: assert rst while addr ACK is being driven -> next cycle sda_oen_n=1, busy=0, state IDLE; following START+addr 0x50/W is ACKed normally.
- Write 0x50/W then 0xA5, 0x3C with rx_en=1:
  - ACK low for exactly one SCL period after each byte.
  - rx_valid pulses twice: rx_data=0xA5 with rx_first=1, then 0x3C with rx_first=0.
  - addr_match=1 throughout; stop_det pulses once at STOP.
- Address 0x51/W: no ACK (sda_oen_n stays 1), no rx_valid, busy=1 until STOP.
- Address 0x50/R: NACK, state IGNORE, following clocked bits produce no rx_valid.
- rx_en=0 during byte 0x77: rx_valid stays 0, 9th bit NACK, further bytes ignored until repeated START.
- Repeated START after 4 data bits: counter reset, addr_match=0. Re-addressing 0x50/W + 0x81 yields rx_valid with rx_data=0x81 and rx_first=1.
